// File: rtl/riscv_pkg.sv
// Shared constants for the instruction-fetch front end.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam int unsigned INST_BYTES       = 4;

endpackage

// File: rtl/ifq_fifo.sv
// Circular FIFO holding fetched {address, instruction} entries.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module ifq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: pc, credit-based ROM requests, jump flush, head to decode.
// Optional macro IFQ_BYPASS_EN presents a live response directly when the queue is empty.
module ifetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jump_en_i,
    input  logic [XLEN-1:0]        jump_addr_i,
    output logic                   rom_req_o,
    output logic [XLEN-1:0]        rom_addr_o,
    input  logic [31:0]            rom_inst_i,
    output logic                   inst_valid_o,
    input  logic                   inst_ready_i,
    output logic [31:0]            inst_o,
    output logic [XLEN-1:0]        inst_addr_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;
    localparam int unsigned EW = XLEN + 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

    logic [XLEN-1:0] r_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_addr;

    logic [CW-1:0]   w_count;
    logic [OW-1:0]   w_occupancy;
    logic            w_issue;
    logic            w_resp_live;
    logic            w_bypass;
    logic            w_bypass_take;
    logic            w_push;
    logic            w_pop;
    logic [EW-1:0]   w_push_data;
    logic [EW-1:0]   w_head;

    // Outstanding request counts against capacity so a push never finds the queue full.
    assign w_occupancy = OW'(w_count) + OW'(r_inflight);
    assign w_issue     = !rst && !jump_en_i && (w_occupancy < OW'(DEPTH));
    assign w_resp_live = r_inflight && !jump_en_i;

`ifdef IFQ_BYPASS_EN
    assign w_bypass      = w_resp_live && (w_count == '0);
    assign w_bypass_take = w_bypass && inst_ready_i;
`else
    assign w_bypass      = 1'b0;
    assign w_bypass_take = 1'b0;
`endif

    assign w_push      = w_resp_live && !w_bypass_take;
    assign w_pop       = (w_count != '0) && inst_ready_i && !jump_en_i;
    assign w_push_data = {r_inflight_addr, rom_inst_i};

    assign rom_req_o  = w_issue;
    assign rom_addr_o = r_pc;
    assign count_o    = w_count;

    // pc and the single in-flight tag; a jump reloads pc and kills the outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else if (jump_en_i) begin
            r_pc       <= jump_addr_i & ALIGN_MASK;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc            <= r_pc + XLEN'(INST_BYTES);
                r_inflight_addr <= r_pc;
            end
        end
    end

    ifq_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (jump_en_i),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Head presentation; an empty queue shows a NOP at address zero.
    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = INST_NOP;
        inst_addr_o  = '0;
        if (w_count != '0) begin
            inst_valid_o = 1'b1;
            inst_o       = w_head[31:0];
            inst_addr_o  = w_head[EW-1:32];
        end else if (w_bypass) begin
            inst_valid_o = 1'b1;
            inst_o       = rom_inst_i;
            inst_addr_o  = r_inflight_addr;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: reset/throughput vector table, jump/wrap/reset corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_ifetch_queue;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic [31:0] rom_inst_i = '0;
    logic        inst_ready_i = 1'b0;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_errors = 0;

    logic        p_req  = 1'b0;
    logic [31:0] p_addr = '0;

    always #5 clk = ~clk;

    ifetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_inst_i   (rom_inst_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .count_o      (count_o)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h00A0_0093 : ((a * 32'd3) ^ 32'h1357_0013);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs just after the edge (ROM answers last cycle's request), sample mid-cycle.
    task automatic step(input logic r, input logic j, input logic [31:0] ja, input logic rdy);
        @(posedge clk);
        #1;
        rom_inst_i   = p_req ? rom_word(p_addr) : 32'hDEAD_BEEF;
        rst          = r;
        jump_en_i    = j;
        jump_addr_i  = ja;
        inst_ready_i = rdy;
        #3;
        p_req  = rom_req_o;
        p_addr = rom_addr_o;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   32'(rom_req_o),    32'd0);
        check({tag, "_count"}, 32'(count_o),      32'd0);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
        check({tag, "_inst"},  inst_o,            INST_NOP);
        check({tag, "_iaddr"}, inst_addr_o,       32'd0);
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check_reset_vals(tag);
    endtask

    // Looks at the current cycle first, then steps with ready=1 until a valid head appears.
    task automatic expect_first_valid(input string tag, input logic [31:0] exp);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && inst_valid_o) begin
                found = 1'b1;
                check(tag, inst_addr_o, exp);
                check({tag, "_inst"}, inst_o, rom_word(exp));
            end
            if (!found) step(1'b0, 1'b0, 32'd0, 1'b1);
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    // Reference model: an ordered list of fetched entries plus the outstanding fetch address.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ia;
    bit          m_infl;

    task automatic model_reset();
        m_q.delete();
        m_pc   = RPC;
        m_ia   = '0;
        m_infl = 1'b0;
    endtask

    task automatic model_check_and_step(input logic j, input logic [31:0] ja, input logic rdy);
        int sz;
        bit live, e_req, bypass, pop;
        sz     = m_q.size();
        live   = m_infl && !j;
        e_req  = !j && ((sz + int'(m_infl)) < int'(DEPTH));
        bypass = BYP && live && (sz == 0);
        check("rnd_req", 32'(rom_req_o), 32'(e_req));
        if (e_req) check("rnd_addr", rom_addr_o, m_pc);
        check("rnd_count", 32'(count_o), 32'(sz));
        check("rnd_valid", 32'(inst_valid_o), 32'((sz != 0) || bypass));
        if (sz != 0) begin
            check("rnd_iaddr", inst_addr_o, m_q[0].addr);
            check("rnd_inst",  inst_o,      m_q[0].inst);
        end else if (bypass) begin
            check("rnd_byp_iaddr", inst_addr_o, m_ia);
            check("rnd_byp_inst",  inst_o,      rom_word(m_ia));
        end
        if (j) begin
            m_q.delete();
            m_infl = 1'b0;
            m_pc   = ja & ~32'd3;
        end else begin
            pop = (sz != 0) && rdy;
            if (pop) void'(m_q.pop_front());
            if (live && !(bypass && rdy)) m_q.push_back('{m_ia, rom_word(m_ia)});
            if (e_req) begin
                m_ia = m_pc;
                m_pc = m_pc + 32'd4;
            end
            m_infl = e_req;
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_iaddr;
        int          e_count;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        tv[22];
        logic        j, rdy;
        logic [31:0] ja;

        // Reset release then a 10-cycle decode stall, cycle by cycle from the release cycle.
        tv[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  0};
        tv[1]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  0};
        tv[2]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0,  1};
        tv[3]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  1};
        tv[4]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8,  1};
        tv[5]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12, 1};
        tv[6]  = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16, 1};
        tv[7]  = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd16, 2};
        tv[8]  = '{1'b0, 1'b0, 32'd32, 1'b1, 32'd16, 3};
        for (int i = 9; i <= 15; i++) tv[i] = '{1'b0, 1'b0, 32'd32, 1'b1, 32'd16, 4};
        tv[16] = '{1'b1, 1'b0, 32'd32, 1'b1, 32'd16, 4};
        tv[17] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd20, 3};
        tv[18] = '{1'b1, 1'b1, 32'd36, 1'b1, 32'd24, 2};
        tv[19] = '{1'b1, 1'b1, 32'd40, 1'b1, 32'd28, 2};
        tv[20] = '{1'b1, 1'b1, 32'd44, 1'b1, 32'd32, 2};
        tv[21] = '{1'b1, 1'b1, 32'd48, 1'b1, 32'd36, 2};

        do_reset("rst0");
`ifndef IFQ_BYPASS_EN
        for (int i = 0; i < 22; i++) begin
            step(1'b0, 1'b0, 32'd0, tv[i].rdy);
            check($sformatf("tv%0d_req", i),   32'(rom_req_o),    32'(tv[i].e_req));
            if (tv[i].e_req) check($sformatf("tv%0d_addr", i), rom_addr_o, tv[i].e_addr);
            check($sformatf("tv%0d_valid", i), 32'(inst_valid_o), 32'(tv[i].e_valid));
            check($sformatf("tv%0d_count", i), 32'(count_o),      32'(tv[i].e_count));
            if (tv[i].e_valid) begin
                check($sformatf("tv%0d_iaddr", i), inst_addr_o, tv[i].e_iaddr);
                check($sformatf("tv%0d_inst", i),  inst_o,      rom_word(tv[i].e_iaddr));
            end
        end
`else
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("byp_rel_req",  32'(rom_req_o), 32'd1);
        check("byp_rel_addr", rom_addr_o,     RPC);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("byp_lat1_valid", 32'(inst_valid_o), 32'd1);
        check("byp_lat1_inst",  inst_o,            32'h00A0_0093);
`endif

        // Jump with three queued entries and a request in flight.
        do_reset("rstA");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        check("a_pre_count", 32'(count_o),   32'd3);
        check("a_jump_req",  32'(rom_req_o), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("a_post_count", 32'(count_o),      32'd0);
        check("a_post_valid", 32'(inst_valid_o), 32'd0);
        check("a_post_req",   32'(rom_req_o),    32'd1);
        check("a_post_addr",  rom_addr_o,        32'h0000_0100);
        expect_first_valid("a_first", 32'h0000_0100);

        // Back-to-back jumps: last target wins.
        step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        check("b_j1_req", 32'(rom_req_o), 32'd0);
        step(1'b0, 1'b1, 32'h0000_0080, 1'b1);
        check("b_j2_req", 32'(rom_req_o), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("b_req",   32'(rom_req_o), 32'd1);
        check("b_addr0", rom_addr_o,     32'h0000_0080);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("b_addr1", rom_addr_o,     32'h0000_0084);
        expect_first_valid("b_first", 32'h0000_0080);

        // pc wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("c_req0",  32'(rom_req_o), 32'd1);
        check("c_addr0", rom_addr_o,     32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        check("c_req1",  32'(rom_req_o), 32'd1);
        check("c_addr1", rom_addr_o,     32'h0000_0000);
        expect_first_valid("c_first", 32'hFFFF_FFFC);

        // Asynchronous mid-cycle reset with two queued entries and one in flight.
        do_reset("rstD");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
        check("d_pre_count", 32'(count_o), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("d_async");
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("d_rel_req",   32'(rom_req_o), 32'd1);
        check("d_rel_addr",  rom_addr_o,     RPC);
        check("d_rel_count", 32'(count_o),   32'd0);
        expect_first_valid("d_first", RPC);

        // Randomized traffic against the reference model.
        do_reset("rstR");
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            j   = ($urandom_range(0, 15) == 0);
            ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            step(1'b0, j, ja, rdy);
            model_check_and_step(j, ja, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
